sr_cmd_gen: RTL and testbench

Front-end stage that drives the S/R inputs of the Lab 6 NOR-based SR latch from two raw, bouncing push-buttons. The block synchronizes and debounces both buttons and converts each clean press into a fixed-width pulse on exactly one of S or R. It guarantees S and R are never high together, which removes the latch's forbidden state. It also requires both buttons to be released before the next command is accepted.

---
 rtl/sr_cmd_pkg.sv | 11 +
 rtl/sr_debounce.sv | 46 ++++
 rtl/sr_cmd_gen.sv | 93 +++++++++
 tb/tb_sr_cmd_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_cmd_pkg.sv
// Shared definitions for the SR latch command generator.
package sr_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULSE_S  = 2'd1,
      PULSE_R  = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

endpackage

// File: rtl/sr_debounce.sv
// Two-FF synchronizer plus saturating debounce counter with a one-cycle press pulse.
module sr_debounce
   import sr_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic deb,
   output logic pressed
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta    <= 1'b0;
         sync    <= 1'b0;
         deb     <= 1'b0;
         cnt     <= '0;
         pressed <= 1'b0;
      end else begin
         meta    <= btn;
         sync    <= meta;
         pressed <= 1'b0;
         if (sync != deb) begin
            // the cycle that would bring cnt to DEBOUNCE_CYCLES commits the new level instead
            if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
               deb     <= ~deb;
               cnt     <= '0;
               pressed <= ~deb;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns two debounced buttons into mutually exclusive fixed-width S/R pulses,
// locking out new commands until both buttons are released.
module sr_cmd_gen
   import sr_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned PULSE_CYCLES    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_set,
   input  logic btn_rst,
   output logic S,
   output logic R,
   output logic busy,
   output logic conflict
);

   localparam int unsigned PW = $clog2(PULSE_CYCLES + 1);

   logic          deb_set;
   logic          deb_rst;
   logic          pressed_set;
   logic          pressed_rst;
   state_t        state;
   logic [PW-1:0] pcnt;

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
      .clk     (clk),
      .rst     (rst),
      .btn     (btn_set),
      .deb     (deb_set),
      .pressed (pressed_set)
   );

   sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rst (
      .clk     (clk),
      .rst     (rst),
      .btn     (btn_rst),
      .deb     (deb_rst),
      .pressed (pressed_rst)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pcnt     <= '0;
         S        <= 1'b0;
         R        <= 1'b0;
         busy     <= 1'b0;
         conflict <= 1'b0;
      end else begin
         conflict <= 1'b0;
         case (state)
            IDLE: begin
               if (pressed_set && pressed_rst) begin
                  conflict <= 1'b1;
                  busy     <= 1'b1;
                  state    <= WAIT_REL;
               end else if (pressed_set) begin
                  S     <= 1'b1;
                  busy  <= 1'b1;
                  pcnt  <= PW'(PULSE_CYCLES - 1);
                  state <= PULSE_S;
               end else if (pressed_rst) begin
                  R     <= 1'b1;
                  busy  <= 1'b1;
                  pcnt  <= PW'(PULSE_CYCLES - 1);
                  state <= PULSE_R;
               end
            end
            PULSE_S, PULSE_R: begin
               // pcnt is loaded with one less than the width since the loading edge already raised the output
               if (pcnt == '0) begin
                  S     <= 1'b0;
                  R     <= 1'b0;
                  state <= WAIT_REL;
               end else begin
                  pcnt <= pcnt - 1'b1;
               end
            end
            WAIT_REL: begin
               if (!deb_set && !deb_rst) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Directed and random checks of sr_cmd_gen against a cycle-stamped command-level model.
module tb_sr_cmd_gen;

   localparam int unsigned DEB = 4;
   localparam int unsigned PUL = 3;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic btn_set = 1'b0;
   logic btn_rst = 1'b0;
   logic S, R, busy, conflict;

   int compared   = 0;
   int mismatched = 0;

   // reference model: per-button sync pipe and stability run, plus a lock flag and pulse budget
   logic m_sy1 [2];
   logic m_sy2 [2];
   logic m_deb [2];
   logic m_prs [2];
   int   m_run [2];
   int   m_left;
   int   m_owner;
   logic m_locked;
   logic m_conf;
   int   s_run;
   int   r_run;

   always #5 clk = ~clk;

   sr_cmd_gen #(.DEBOUNCE_CYCLES(DEB), .PULSE_CYCLES(PUL)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_set  (btn_set),
      .btn_rst  (btn_rst),
      .S        (S),
      .R        (R),
      .busy     (busy),
      .conflict (conflict)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      compared++;
      assert (obs === exp_v) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         m_sy1[b] = 1'b0;
         m_sy2[b] = 1'b0;
         m_deb[b] = 1'b0;
         m_prs[b] = 1'b0;
         m_run[b] = 0;
      end
      m_left   = 0;
      m_owner  = 0;
      m_locked = 1'b0;
      m_conf   = 1'b0;
   endtask

   task automatic model_edge();
      logic raw [2];
      raw[0] = btn_set;
      raw[1] = btn_rst;
      m_conf = 1'b0;
      if (!m_locked) begin
         if (m_prs[0] && m_prs[1]) begin
            m_conf   = 1'b1;
            m_locked = 1'b1;
            m_left   = 0;
         end else if (m_prs[0] || m_prs[1]) begin
            m_owner  = m_prs[0] ? 0 : 1;
            m_left   = PUL;
            m_locked = 1'b1;
         end
      end else if (m_left > 0) begin
         m_left--;
      end else if (!m_deb[0] && !m_deb[1]) begin
         m_locked = 1'b0;
      end
      for (int b = 0; b < 2; b++) begin
         m_prs[b] = 1'b0;
         if (m_sy2[b] != m_deb[b]) begin
            m_run[b]++;
            if (m_run[b] == DEB) begin
               m_deb[b] = ~m_deb[b];
               m_run[b] = 0;
               m_prs[b] = m_deb[b];
            end
         end else begin
            m_run[b] = 0;
         end
         m_sy2[b] = m_sy1[b];
         m_sy1[b] = raw[b];
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_reset();
      else     model_edge();
      #1;
      check("S",        S,        32'(m_locked && m_left > 0 && m_owner == 0));
      check("R",        R,        32'(m_locked && m_left > 0 && m_owner == 1));
      check("busy",     busy,     32'(m_locked));
      check("conflict", conflict, 32'(m_conf));
      check("s_and_r",  S & R,    0);
      if (S === 1'b1) s_run++;
      else if (s_run != 0) begin
         check("s_width", s_run, PUL);
         s_run = 0;
      end
      if (R === 1'b1) r_run++;
      else if (r_run != 0) begin
         check("r_width", r_run, PUL);
         r_run = 0;
      end
   endtask

   // step j of the window is edge k+j, k being the first edge to see the new button level
   task automatic pulse_window(input string tag, input bit want_s, input bit want_r);
      for (int j = 0; j <= 10; j++) begin
         step();
         check({tag, "_S"}, S, 32'(want_s && j >= 6 && j <= 8));
         check({tag, "_R"}, R, 32'(want_r && j >= 6 && j <= 8));
      end
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (busy === 1'b0) break;
         step();
      end
      check(tag, busy, 0);
   endtask

   initial begin
      int cnt_a;
      int cnt_b;
      s_run = 0;
      r_run = 0;
      model_reset();

      // reset state
      for (int i = 0; i < 3; i++) step();
      check("rst_S", S, 0);
      check("rst_R", R, 0);
      check("rst_busy", busy, 0);
      check("rst_conflict", conflict, 0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step();

      // clean press
      btn_set = 1'b1;
      pulse_window("clean", 1'b1, 1'b0);
      check("clean_busy_held", busy, 1);
      btn_set = 1'b0;
      wait_idle("clean_idle");

      // bounce rejection
      btn_set = 1'b1; step();
      btn_set = 1'b0; step();
      btn_set = 1'b1; step();
      btn_set = 1'b0; step();
      check("bounce_no_early", busy, 0);
      btn_set = 1'b1;
      pulse_window("bounce", 1'b1, 1'b0);
      btn_set = 1'b0;
      wait_idle("bounce_idle");

      // simultaneous press
      btn_set = 1'b1;
      btn_rst = 1'b1;
      cnt_a = 0;
      cnt_b = 0;
      for (int j = 0; j <= 12; j++) begin
         step();
         check("sim_conflict_at", conflict, 32'(j == 6));
         if (conflict === 1'b1) cnt_a++;
         if (S === 1'b1 || R === 1'b1) cnt_b++;
      end
      check("sim_conflict_count", cnt_a, 1);
      check("sim_no_sr", cnt_b, 0);
      btn_set = 1'b0;
      for (int i = 0; i < 15; i++) step();
      check("sim_busy_one_held", busy, 1);
      btn_rst = 1'b0;
      wait_idle("sim_idle");

      // lockout: reset press while set is held is ignored
      btn_set = 1'b1;
      pulse_window("lock_set", 1'b1, 1'b0);
      btn_rst = 1'b1;
      cnt_a = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (R === 1'b1) cnt_a++;
      end
      check("lock_no_r", cnt_a, 0);
      btn_set = 1'b0;
      btn_rst = 1'b0;
      wait_idle("lock_idle");
      btn_rst = 1'b1;
      pulse_window("lock_r", 1'b0, 1'b1);
      btn_rst = 1'b0;
      wait_idle("lock_r_idle");

      // async reset during the second S cycle
      btn_set = 1'b1;
      for (int j = 0; j <= 7; j++) step();
      check("areset_pre_S", S, 1);
      #2;
      rst = 1'b1;
      model_reset();
      s_run = 0;
      #1;
      check("areset_S", S, 0);
      check("areset_busy", busy, 0);
      step();
      rst = 1'b0;
      pulse_window("areset_relaunch", 1'b1, 1'b0);
      btn_set = 1'b0;
      wait_idle("areset_idle");

      // random buttons
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(7) == 0) btn_set = ~btn_set;
         if ($urandom_range(7) == 0) btn_rst = ~btn_rst;
         step();
      end
      btn_set = 1'b0;
      btn_rst = 1'b0;
      for (int i = 0; i < 8; i++) step();
      wait_idle("random_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
